// File: rtl/flp_tree_sequencer.sv
// flp_tree_sequencer: packs a serial operand stream onto the adder-tree bus and captures its result after a fixed latency
module flp_tree_sequencer #(
  parameter int NUM_INPUTS   = 10,
  parameter int EXP_WIDTH    = 9,
  parameter int MANT_WIDTH   = 8,
  parameter int TREE_LATENCY = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             flush,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [MANT_WIDTH-1:0]            in_data,
  output logic [NUM_INPUTS*MANT_WIDTH-1:0] tree_bus,
  input  logic [EXP_WIDTH-1:0]             tree_exp,
  input  logic [MANT_WIDTH-1:0]            tree_mant,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [EXP_WIDTH-1:0]             out_exp,
  output logic [MANT_WIDTH-1:0]            out_mant,
  output logic                             busy
);
  localparam int IW = $clog2(NUM_INPUTS);
  localparam int WW = $clog2(TREE_LATENCY) + 1;

  typedef enum logic [1:0] {COLLECT, WAIT, HOLD} state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] idx;
  logic [WW-1:0] wait_cnt;
  logic          accept, last_slot, wait_done;

  assign in_ready  = state == COLLECT;
  assign busy      = state != COLLECT;
  assign out_valid = state == HOLD;
  assign accept    = in_valid && in_ready && !flush;
  assign last_slot = idx == IW'(NUM_INPUTS - 1);
  assign wait_done = wait_cnt == WW'(TREE_LATENCY - 1);

  // State register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= COLLECT;
    else state <= state_nxt;

  // Next state: flush wins, then the per-state handshake/timeout
  always_comb begin
    state_nxt = state;
    if (flush) state_nxt = COLLECT;
    else if (accept && last_slot) state_nxt = WAIT;
    else if (state == WAIT && wait_done) state_nxt = HOLD;
    else if (state == HOLD && out_ready) state_nxt = COLLECT;
  end

  // Slot writes, latency counter and result capture; flush leaves bus and result untouched
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      idx      <= '0;
      wait_cnt <= '0;
      tree_bus <= '0;
      out_exp  <= '0;
      out_mant <= '0;
    end else if (flush) begin
      idx      <= '0;
      wait_cnt <= '0;
    end else if (accept) begin
      tree_bus[idx*MANT_WIDTH +: MANT_WIDTH] <= in_data;
      idx      <= last_slot ? '0 : idx + 1'b1;
      wait_cnt <= '0;
    end else if (state == WAIT) begin
      wait_cnt <= wait_done ? wait_cnt : wait_cnt + 1'b1;
      if (wait_done) begin
        out_exp  <= tree_exp;
        out_mant <= tree_mant;
      end
    end
endmodule

// File: tb/tb_flp_tree_sequencer.sv
// tb_flp_tree_sequencer: directed and random stimulus against a cycle-timestamp reference model
module tb_flp_tree_sequencer;
  localparam int N  = 10;
  localparam int EW = 9;
  localparam int MW = 8;
  localparam int L  = 4;

  logic          clk = 0, rst_n = 0, flush = 0, in_valid = 0, out_ready = 0;
  logic [MW-1:0] in_data = 0, tree_mant = 0;
  logic [EW-1:0] tree_exp = 0;
  logic          in_ready, out_valid, busy;
  logic [N*MW-1:0] tree_bus;
  logic [EW-1:0] out_exp;
  logic [MW-1:0] out_mant;

  int checks = 0, errors = 0;

  flp_tree_sequencer #(.NUM_INPUTS(N), .EXP_WIDTH(EW), .MANT_WIDTH(MW), .TREE_LATENCY(L)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .tree_bus(tree_bus), .tree_exp(tree_exp), .tree_mant(tree_mant),
    .out_valid(out_valid), .out_ready(out_ready), .out_exp(out_exp), .out_mant(out_mant),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference model: operands land in slots in arrival order; the result is the tree
  // value present exactly L edges after the edge that took the last operand.
  logic [MW-1:0] m_slots [N];
  int            m_n, m_edge, m_due;
  bit            m_hold;
  logic [EW-1:0] m_exp;
  logic [MW-1:0] m_mant;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, got, want);
    end
  endtask

  function automatic logic [N*MW-1:0] m_bus();
    logic [N*MW-1:0] b;
    for (int k = 0; k < N; k++) b[k*MW +: MW] = m_slots[k];
    return b;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < N; k++) m_slots[k] = '0;
    m_n = 0; m_due = -1; m_hold = 0; m_exp = '0; m_mant = '0;
  endtask

  task automatic check_all(input string tag);
    bit collecting;
    collecting = m_due < 0 && !m_hold;
    check({tag, ".in_ready"}, in_ready, collecting);
    check({tag, ".busy"}, busy, !collecting);
    check({tag, ".out_valid"}, out_valid, m_hold);
    check({tag, ".out_exp"}, out_exp, m_exp);
    check({tag, ".out_mant"}, out_mant, m_mant);
    check({tag, ".tree_bus"}, tree_bus, m_bus());
  endtask

  // One clock: drive at negedge, advance model at the edge, check at next negedge
  task automatic cycle(input string tag, input bit iv, input logic [MW-1:0] d, input bit fl,
                       input bit ordy, input logic [EW-1:0] te, input logic [MW-1:0] tm);
    bit collecting;
    in_valid = iv; in_data = d; flush = fl; out_ready = ordy; tree_exp = te; tree_mant = tm;
    collecting = m_due < 0 && !m_hold;
    @(posedge clk);
    m_edge++;
    if (fl) begin
      m_n = 0; m_due = -1; m_hold = 0;
    end else if (collecting) begin
      if (iv) begin
        m_slots[m_n] = d;
        m_n++;
        if (m_n == N) begin m_n = 0; m_due = m_edge + L; end
      end
    end else if (m_due == m_edge) begin
      m_exp = te; m_mant = tm; m_hold = 1; m_due = -1;
    end else if (m_hold && ordy) m_hold = 0;
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic rnd_cycle(input string tag, input bit iv, input logic [MW-1:0] d, input bit ordy);
    cycle(tag, iv, d, 1'b0, ordy, EW'($urandom), MW'($urandom));
  endtask

  initial begin
    model_reset();
    m_edge = 0;
    #12;
    check_all("reset");
    @(negedge clk) rst_n = 1;
    cycle("post_reset", 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < N; i++) cycle("basic_in", 1, MW'(i + 1), 0, 0, 9'h123, 8'h5A);
    check("basic.slot0", tree_bus[7:0], 8'h01);
    check("basic.slot9", tree_bus[N*MW-1 -: MW], 8'h0A);
    check("basic.in_ready_low", in_ready, 1'b0);
    for (int i = 0; i < L; i++) cycle("basic_wait", 0, 0, 0, 0, 9'h123, 8'h5A);
    check("basic.out_valid", out_valid, 1'b1);
    check("basic.out_exp", out_exp, 9'h123);
    check("basic.out_mant", out_mant, 8'h5A);

    for (int i = 0; i < 20; i++) rnd_cycle("backpressure", 1, MW'($urandom), 0);
    cycle("release", 0, 0, 0, 1, 0, 0);
    check("release.out_valid", out_valid, 1'b0);
    check("release.in_ready", in_ready, 1'b1);

    for (int i = 0; i < 2 * N; i++) rnd_cycle("gapped_in", i % 2 == 0, MW'($urandom), 0);
    for (int i = 0; i < L + 3; i++) rnd_cycle("gapped_wait", 1, MW'($urandom), 0);
    cycle("gapped_release", 0, 0, 0, 1, 0, 0);

    for (int i = 0; i < 5; i++) rnd_cycle("pre_flush", 1, MW'($urandom), 0);
    cycle("flush_collect", 1, 8'hEE, 1, 0, 0, 0);
    for (int i = 0; i < N; i++) rnd_cycle("flush_refill", 1, MW'(8'hF0 + i), 0);
    check("refill.slot0", tree_bus[7:0], 8'hF0);
    check("refill.slot9", tree_bus[N*MW-1 -: MW], 8'hF9);
    for (int i = 0; i < L + 2; i++) rnd_cycle("refill_wait", 0, 0, 0);
    cycle("flush_hold", 0, 0, 1, 0, 0, 0);
    check("flush_hold.out_valid", out_valid, 1'b0);

    for (int i = 0; i < 3000; i++)
      cycle("random", $urandom_range(9) < 7, MW'($urandom), $urandom_range(39) == 0,
            $urandom_range(1) == 1, EW'($urandom), MW'($urandom));

    for (int i = 0; i < N; i++) rnd_cycle("areset_in", 1, MW'($urandom), 0);
    rnd_cycle("areset_wait", 0, 0, 0);
    #2 rst_n = 0;
    #1;
    model_reset();
    check("areset.busy", busy, 1'b0);
    check("areset.out_valid", out_valid, 1'b0);
    check_all("areset");
    @(negedge clk) rst_n = 1;
    for (int i = 0; i < 3; i++) rnd_cycle("after_areset", 1, MW'($urandom), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
